// File: rtl/logistic_orbit_scheduler.sv
// Time-multiplexed logistic-map iterator: N_CH orbits share one registered 18x18 multiplier.
// Optional LOGISTIC_ROUND_EN: round-half-up with saturation on each written orbit value.
module logistic_orbit_scheduler #(
  parameter int N_CH    = 7,
  parameter int MUL_LAT = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [8:0]           times,
  input  logic [17:0]          mu,
  input  logic [16:0]          seed_base,
  output logic                 busy,
  output logic                 done,
  output logic [8:0]           step_count,
  output logic [N_CH*17-1:0]   result_flat
);

  localparam int            CW        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST_CH   = CW'(N_CH - 1);
  localparam logic [2:0]    LAST_WAIT = 3'(MUL_LAT - 1);

  typedef enum logic [2:0] {IDLE, SEED, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, WRITE} state_t;

  state_t        state, state_nxt;
  logic [8:0]    times_sh;
  logic [17:0]   mu_sh;
  logic [16:0]   result [N_CH];
  logic [CW-1:0] ch_ptr;
  logic [2:0]    wait_cnt;
  logic [35:0]   mul_p [MUL_LAT];
  logic [35:0]   prod_hold;
  logic [17:0]   op_a, op_b;
  logic [16:0]   x_cur, y_cur;
  logic          fin, accept, last_step, finish;

`ifdef LOGISTIC_ROUND_EN
  function automatic logic [16:0] round_sat(input logic [35:0] p);
    logic [36:0] s;
    s = {1'b0, p} + 37'h8000;
    return (s[36:33] != 4'd0) ? 17'h1FFFF : s[32:16];
  endfunction
  assign y_cur = round_sat(prod_hold);
`else
  logic unused_prod_bits;
  assign unused_prod_bits = ^{prod_hold[35:34], prod_hold[15:0]};
  assign y_cur = prod_hold[32:16];
`endif

  assign x_cur     = result[ch_ptr];
  assign accept    = start & ~abort & ~busy & (state == IDLE);
  assign last_step = (ch_ptr == LAST_CH) && ((step_count + 9'd1) == times_sh);
  assign finish    = ~abort & (((state == SEED) && (times_sh == 9'd0)) ||
                               ((state == WRITE) && last_step));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = SEED;
        SEED:    state_nxt = (times_sh == 9'd0) ? IDLE : ISSUE_A;
        ISSUE_A: state_nxt = WAIT_A;
        WAIT_A:  if (wait_cnt == LAST_WAIT) state_nxt = ISSUE_B;
        ISSUE_B: state_nxt = WAIT_B;
        WAIT_B:  if (wait_cnt == LAST_WAIT) state_nxt = WRITE;
        WRITE:   state_nxt = last_step ? IDLE : ISSUE_A;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand select: 1-x is clamped at zero so overshooting orbits collapse instead of wrapping.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == ISSUE_A) begin
      op_a = {1'b0, x_cur};
      op_b = (x_cur >= 17'h10000) ? 18'd0 : (18'h10000 - {1'b0, x_cur});
    end else if (state == ISSUE_B) begin
      op_a = mu_sh;
      op_b = prod_hold[33:16];
    end
  end

  // Multiplier pipeline stages
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < MUL_LAT; i++) mul_p[i] <= '0;
    end else begin
      mul_p[0] <= 36'(op_a) * 36'(op_b);
      for (int i = 1; i < MUL_LAT; i++) mul_p[i] <= mul_p[i-1];
    end
  end

  // Sequencing, product capture and orbit write-back
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      fin        <= 1'b0;
      step_count <= '0;
      ch_ptr     <= '0;
      wait_cnt   <= '0;
      times_sh   <= '0;
      mu_sh      <= '0;
      prod_hold  <= '0;
      for (int k = 0; k < N_CH; k++) result[k] <= '0;
    end else begin
      done <= fin & ~abort;
      fin  <= finish;
      busy <= ~abort & (state != IDLE);
      if (abort) begin
        wait_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            times_sh <= times;
            mu_sh    <= mu;
          end
          SEED: begin
            for (int k = 0; k < N_CH; k++) result[k] <= seed_base + 17'(k);
            ch_ptr     <= '0;
            step_count <= '0;
          end
          WAIT_A, WAIT_B: begin
            // The pipeline keeps shifting, so the product is captured on the last wait cycle.
            if (wait_cnt == LAST_WAIT) begin
              wait_cnt  <= '0;
              prod_hold <= mul_p[MUL_LAT-1];
            end else begin
              wait_cnt <= wait_cnt + 3'd1;
            end
          end
          WRITE: begin
            result[ch_ptr] <= y_cur;
            if (ch_ptr == LAST_CH) begin
              ch_ptr     <= '0;
              step_count <= step_count + 9'd1;
            end else begin
              ch_ptr <= ch_ptr + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_flat
    assign result_flat[17*k +: 17] = result[k];
  end

endmodule

// File: tb/tb_logistic_orbit_scheduler.sv
// Bench for logistic_orbit_scheduler: scenario tasks checked against a plain-arithmetic orbit model.
module tb_logistic_orbit_scheduler;
  localparam int N = 4;
  localparam int L = 2;
  localparam int STEP = 2 * L + 3;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [8:0]     times = '0;
  logic [17:0]    mu = '0;
  logic [16:0]    seed_base = '0;
  logic           busy, done;
  logic [8:0]     step_count;
  logic [N*17-1:0] result_flat;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_res [N];

  logistic_orbit_scheduler #(.N_CH(N), .MUL_LAT(L)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .times(times), .mu(mu),
    .seed_base(seed_base), .busy(busy), .done(done), .step_count(step_count),
    .result_flat(result_flat)
  );

  always #5 CLK = ~CLK;

  function automatic logic [16:0] res(input int k);
    return result_flat[17*k +: 17];
  endfunction

  function automatic longint logistic_step(input longint mu_v, input longint x);
    longint b, t, p, y;
    b = (x >= 65536) ? 0 : 65536 - x;
    t = ((x * b) >> 16) & 'h3FFFF;
    p = mu_v * t;
`ifdef LOGISTIC_ROUND_EN
    p = p + 'h8000;
    if ((p >> 33) != 0) y = 'h1FFFF;
    else y = (p >> 16) & 'h1FFFF;
`else
    y = (p >> 16) & 'h1FFFF;
`endif
    return y;
  endfunction

  task automatic model_run(input longint mu_v, input longint seed, input int nt);
    longint x;
    for (int k = 0; k < N; k++) begin
      x = (seed + k) % 131072;
      for (int s = 0; s < nt; s++) x = logistic_step(mu_v, x);
      exp_res[k] = 17'(x);
    end
  endtask

  task automatic launch(input logic [17:0] m, input logic [16:0] s, input logic [8:0] t);
    @(negedge CLK);
    mu = m; seed_base = s; times = t; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edge_n);
    edge_n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge CLK); #1;
      if (done) begin edge_n = i; break; end
    end
  endtask

  task automatic test_reset;
    @(posedge CLK); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (step_count !== 9'd0) begin errors++; $display("FAIL reset_steps got=%0d want=0", step_count); end
    checks++; if (result_flat !== '0) begin errors++; $display("FAIL reset_results got=%h want=0", result_flat); end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_fixed_point;
    int de;
    launch(18'h20000, 17'h08000, 9'd3);
    wait_done(500, de);
    checks++; if (de !== 86) begin errors++; $display("FAIL fixed_latency got=%0d want=86", de); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixed_busy_at_done got=%0b want=0", busy); end
    checks++; if (res(0) !== 17'h08000) begin errors++; $display("FAIL fixed_r0 got=%h want=08000", res(0)); end
    checks++; if (step_count !== 9'd3) begin errors++; $display("FAIL fixed_steps got=%0d want=3", step_count); end
    model_run(64'h20000, 64'h8000, 3);
    for (int k = 1; k < N; k++) begin
      checks++;
      if (res(k) !== exp_res[k]) begin errors++; $display("FAIL fixed_r%0d got=%h want=%h", k, res(k), exp_res[k]); end
    end
    @(posedge CLK); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%0b want=0", done); end
  endtask

  task automatic test_identity;
    launch(18'h10000, 17'h08000, 9'd1);
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (busy !== (i <= 29)) begin errors++; $display("FAIL ident_busy edge=%0d got=%0b want=%0b", i, busy, (i <= 29)); end
      checks++;
      if (done !== (i == 30)) begin errors++; $display("FAIL ident_done edge=%0d got=%0b want=%0b", i, done, (i == 30)); end
    end
    checks++; if (res(0) !== 17'h04000) begin errors++; $display("FAIL ident_r0 got=%h want=04000", res(0)); end
  endtask

  task automatic test_times_zero;
    int de;
    logic [16:0] w [N];
    w[0] = 17'h1FFFE; w[1] = 17'h1FFFF; w[2] = 17'h00000; w[3] = 17'h00001;
    launch(18'h20000, 17'h1FFFE, 9'd0);
    wait_done(50, de);
    checks++; if (de !== 2) begin errors++; $display("FAIL zero_latency got=%0d want=2", de); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (res(k) !== w[k]) begin errors++; $display("FAIL zero_r%0d got=%h want=%h", k, res(k), w[k]); end
    end
    checks++; if (step_count !== 9'd0) begin errors++; $display("FAIL zero_steps got=%0d want=0", step_count); end
  endtask

  task automatic test_round;
    int de;
    logic [16:0] want;
`ifdef LOGISTIC_ROUND_EN
    want = 17'h10000;
`else
    want = 17'h0FFFF;
`endif
    launch(18'h3FFFF, 17'h08000, 9'd1);
    wait_done(100, de);
    checks++; if (de !== 30) begin errors++; $display("FAIL round_latency got=%0d want=30", de); end
    checks++; if (res(0) !== want) begin errors++; $display("FAIL round_r0 got=%h want=%h", res(0), want); end
  endtask

  task automatic test_random;
    int de, nt;
    logic [17:0] m;
    logic [16:0] s;
    for (int r = 0; r < 8; r++) begin
      nt = $urandom_range(1, 3);
      m = 18'($urandom);
      s = (r < 2) ? 17'(17'h0FFFE + 17'(r)) : 17'($urandom);
      launch(m, s, 9'(nt));
      wait_done(1000, de);
      checks++;
      if (de !== 2 + nt * N * STEP) begin errors++; $display("FAIL rand%0d_latency got=%0d want=%0d", r, de, 2 + nt * N * STEP); end
      checks++;
      if (step_count !== 9'(nt)) begin errors++; $display("FAIL rand%0d_steps got=%0d want=%0d", r, step_count, nt); end
      model_run(longint'(m), longint'(s), nt);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (res(k) !== exp_res[k]) begin errors++; $display("FAIL rand%0d_r%0d got=%h want=%h", r, k, res(k), exp_res[k]); end
      end
    end
  endtask

  task automatic test_abort;
    int de, dones;
    launch(18'h10000, 17'h08000, 9'd5);
    repeat (19) begin @(posedge CLK); #1; end
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    @(posedge CLK); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b want=0", busy); end
    dones = 0;
    repeat (60) begin @(posedge CLK); #1; if (done) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done_pulses got=%0d want=0", dones); end
    checks++; if (step_count !== 9'd0) begin errors++; $display("FAIL abort_steps got=%0d want=0", step_count); end
    model_run(64'h10000, 64'h8000, 1);
    exp_res[2] = 17'h08002; exp_res[3] = 17'h08003;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (res(k) !== exp_res[k]) begin errors++; $display("FAIL abort_r%0d got=%h want=%h", k, res(k), exp_res[k]); end
    end
    launch(18'h20000, 17'h08000, 9'd1);
    wait_done(100, de);
    checks++; if (de !== 30) begin errors++; $display("FAIL abort_restart_latency got=%0d want=30", de); end
    model_run(64'h20000, 64'h8000, 1);
    checks++; if (res(1) !== exp_res[1]) begin errors++; $display("FAIL abort_restart_r1 got=%h want=%h", res(1), exp_res[1]); end
  endtask

  task automatic test_back_to_back;
    int de;
    de = -1;
    launch(18'h20000, 17'h08000, 9'd2);
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK); #1;
      if (done) begin de = i; break; end
      if (i == 10) begin start = 1'b1; mu = 18'h10000; times = 9'd1; end
      else begin start = 1'b0; mu = 18'($urandom); times = 9'($urandom); end
    end
    start = 1'b0;
    checks++; if (de !== 58) begin errors++; $display("FAIL restart_ignored_latency got=%0d want=58", de); end
    checks++; if (step_count !== 9'd2) begin errors++; $display("FAIL restart_ignored_steps got=%0d want=2", step_count); end
    model_run(64'h20000, 64'h8000, 2);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (res(k) !== exp_res[k]) begin errors++; $display("FAIL restart_ignored_r%0d got=%h want=%h", k, res(k), exp_res[k]); end
    end
  endtask

  task automatic test_reset_mid_run;
    launch(18'h10000, 17'h08001, 9'd3);
    repeat (15) begin @(posedge CLK); #1; end
    RST = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    checks++; if (step_count !== 9'd0) begin errors++; $display("FAIL midrst_steps got=%0d want=0", step_count); end
    checks++; if (result_flat !== '0) begin errors++; $display("FAIL midrst_results got=%h want=0", result_flat); end
    @(negedge CLK); RST = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%0b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_fixed_point();
    test_identity();
    test_times_zero();
    test_round();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/logistic_orbit_scheduler.md
Name: logistic_orbit_scheduler

Overview:
- Time-multiplexes one registered 18x18 multiplier across N_CH independent logistic-map orbits: x_next = mu*x*(1-x).
- Replaces N_CH parallel combinational evaluators in the chaos-map display path.
- Seeds every channel on start and iterates all channels round-robin for a programmed number of steps.
- Exposes all orbit values flattened for the pixel colour-select logic and pulses done when finished.

Parameters:
- N_CH, 7, number of orbit channels (2..16).
- MUL_LAT, 2, multiplier pipeline latency in cycles (1..4).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse; seeds channels and begins iterating; ignored while busy.
- abort  input  1  level; forces return to IDLE.
- times  input  9  iterations per channel; sampled on start.
- mu  input  18  Q2.16 parameter (0x10000 = 1.0); sampled on start.
- seed_base  input  17  Q1.16 seed; channel k seed = seed_base + k, 17-bit wrap.
- busy  output  1  high from the cycle after start is accepted until done or abort.
- done  output  1  one-cycle pulse on completion.
- step_count  output  9  completed full rounds (all channels advanced).
- result_flat  output  N_CH*17  channel k occupies bits [17k+16:17k].

Behaviour:
- Reset: FSM=IDLE; busy=0, done=0, step_count=0, all results=0, multiplier pipeline cleared. Reset is honoured mid-operation.
- FSM states: IDLE, SEED, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, WRITE.
- IDLE:
  - start=1 latches times and mu into shadow registers and moves to SEED.
  - Any other cycle holds results.
- SEED (1 cycle):
  - Every result[k] <= seed_base + k; ch_ptr=0; step_count=0.
  - If times==0, go straight to completion; otherwise go to ISSUE_A.
- ISSUE_A (1 cycle):
  - x = result[ch_ptr].
  - Operands: a = x, b = (x >= 0x10000) ? 0 : 0x10000 - x, so negative values clamp to 0.
- WAIT_A: MUL_LAT cycles; then term18 = product[33:16].
- ISSUE_B (1 cycle): a = mu_shadow, b = term18.
- WAIT_B: MUL_LAT cycles.
- WRITE (1 cycle):
  - result[ch_ptr] <= y, where y = product[32:16].
  - If ch_ptr == N_CH-1: ch_ptr=0 and step_count++. Otherwise ch_ptr++.
  - If step_count reaches times, go to completion; otherwise go to ISSUE_A.
- Per channel step: 2*MUL_LAT+3 cycles.
- Completion:
  - Return to IDLE; busy falls and done pulses in the same cycle.
  - done is asserted exactly 2 + times*N_CH*(2*MUL_LAT+3) edges after the start-sampling edge.
- Only the addressed channel updates in WRITE. Other channels hold their values, so result_flat shows mixed iteration depths while busy.
- abort (priority over start):
  - FSM goes to IDLE at the next edge and busy=0.
  - No done pulse.
  - Results and step_count freeze at their partial values.
  - Any in-flight product is discarded.
- start while busy: ignored, and the shadow registers do not change.
- start and abort in the same IDLE cycle: abort wins, start is ignored.
- mu or times changing while busy: no effect, because the shadow registers are used.
- Multiplier: single instance, fully registered, MUL_LAT stages, unsigned 18x18 to 36 bits.

Optional Feature:
- Macro LOGISTIC_ROUND_EN.
- Defined: in WRITE, y = (product + 0x8000)[32:16], round-half-up. If product[35:33] is nonzero after rounding, y saturates to 0x1FFFF.
- Undefined: y = product[32:16], plain truncation.
- Step latency is identical in both builds.

Test Plan:
- N_CH=4, MUL_LAT=2, mu=0x20000, seed_base=0x8000, times=3 -> done at edge 86 after start. result[0]=0x8000 (fixed point). step_count=3.
- mu=0x10000, seed_base=0x8000, times=1 -> result[0]=0x4000. done at edge 30. busy high edges 1..29.
- times=0, seed_base=0x1FFFE -> done at edge 2. Results: 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 (wrap). Channel 1 would then clamp term to 0.
- mu=0x3FFFF, seed 0x8000, times=1 -> with LOGISTIC_ROUND_EN, result[0]=0x10000. Without it, result[0]=0xFFFF.
- abort asserted 20 edges after start with times=5 -> no done, busy=0 next edge, step_count=0, result[0..1] updated, result[2..3] still seeds. A new start then completes normally.
- start re-pulsed mid-run with mu=0x10000 while original mu=0x20000 -> ignored; final results match the mu=0x20000 run. Asserting RST mid-run zeroes all outputs immediately.
